// File: rtl/instr_mem_loader.sv
// instr_mem_loader: length-prefixed byte-stream boot loader that fills instruction memory, then releases the core.
// Optional trailing XOR checksum byte is enabled with `define INSTR_LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_CAPACITY = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic [DATA_WIDTH-1:0] instr_mem_address,
    output logic [DATA_WIDTH-1:0] instr_mem_data,
    output logic                  instr_mem_we,
    output logic                  core_en,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int BPW = DATA_WIDTH / 8;

`ifdef INSTR_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CHK, DONE, ERROR} state_t;
    localparam state_t FIN = CHK;
`else
    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERROR} state_t;
    localparam state_t FIN = DONE;
`endif

    state_t                state_q;
    logic [7:0]            cnt_q;
    logic [31:0]           len_q;
    logic [DATA_WIDTH-1:0] sh_q;
    logic [DATA_WIDTH-1:0] idx_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [31:0]           len_d;
    logic [DATA_WIDTH-1:0] word_d;
    logic [DATA_WIDTH-1:0] idx_d;
    logic                  xfer;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]            chk_q;
`endif

    assign xfer   = byte_valid & byte_ready;
    assign len_d  = {byte_data, len_q[31:8]};
    assign word_d = (sh_q >> 8) | (DATA_WIDTH'(byte_data) << (DATA_WIDTH - 8));
    assign idx_d  = idx_q + DATA_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            sh_q    <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE, ERROR: if (start) begin
                    state_q <= LEN;
                    cnt_q   <= '0;
                    idx_q   <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    chk_q   <= '0;
`endif
                end
                LEN: if (xfer) begin
                    len_q <= len_d;
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == 8'd3) begin
                        cnt_q   <= '0;
                        state_q <= len_d > 32'(MEM_CAPACITY) ? ERROR : len_d == 32'd0 ? FIN : DATA;
                    end
                end
                DATA: if (xfer) begin
                    sh_q  <= word_d;
                    cnt_q <= cnt_q + 8'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    chk_q <= chk_q ^ byte_data;
`endif
                    if (cnt_q == 8'(BPW - 1)) begin
                        cnt_q   <= '0;
                        data_q  <= word_d;
                        addr_q  <= idx_q;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    idx_q   <= idx_d;
                    state_q <= idx_d == DATA_WIDTH'(len_q) ? FIN : DATA;
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                CHK: if (xfer) state_q <= byte_data == chk_q ? DONE : ERROR;
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of the state flop, so they change only on clock edges.
`ifdef INSTR_LOADER_CHECKSUM_EN
    assign byte_ready = state_q == LEN || state_q == DATA || state_q == CHK;
    assign busy       = byte_ready || state_q == WRITE;
`else
    assign byte_ready = state_q == LEN || state_q == DATA;
    assign busy       = byte_ready || state_q == WRITE;
`endif
    assign instr_mem_we      = state_q == WRITE;
    assign instr_mem_address = addr_q;
    assign instr_mem_data    = data_q;
    assign core_en           = state_q == DONE;
    assign done              = state_q == DONE;
    assign error             = state_q == ERROR;
endmodule
